kvadd2_adder_arbiter: RTL and testbench

Packet-granular round-robin arbiter sharing one `kvadd2_example_adder` instance between `C_NUM_REQ` AXI4-Stream requesters. Each requester supplies its own 32-bit add constant. The arbiter forwards whole packets (first beat through `tlast`) to the adder's slave stream. It tags each beat with the requester index on `tid`, and presents that requester's constant on `ctrl_constant`, aligned to the beat. It sits between the kernel's read-side stream sources and the adder, in the `aclk` domain.

---
 rtl/kvadd2_pkg.sv | 29 ++
 rtl/kvadd2_rr_arbiter.sv | 23 ++
 rtl/kvadd2_adder_arbiter.sv | 159 +++++++++++++++
 tb/tb_kvadd2_adder_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kvadd2_pkg.sv
// rtl/kvadd2_pkg.sv - shared state type, index width and round-robin search for the adder arbiter
package kvadd2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int LP_MAX_REQ = 8;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit strictly after ptr, wrapping modulo n; descending scan so the nearest wins.
  function automatic int rr_first(input logic [LP_MAX_REQ-1:0] req, input int ptr, input int n);
    int         pick;
    int         idx;
    logic [2:0] sel;
    pick = 0;
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      sel = 3'(idx);
      if (req[sel]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/kvadd2_rr_arbiter.sv
// rtl/kvadd2_rr_arbiter.sv - combinational round-robin pick starting after rr_ptr
module kvadd2_rr_arbiter
  import kvadd2_pkg::*;
#(
  parameter int C_NUM_REQ = 2,
  parameter int IDX_W     = 1
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_req
);

  logic [LP_MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[C_NUM_REQ-1:0] = req;
    grant_idx              = IDX_W'(rr_first(req_ext, int'(rr_ptr), C_NUM_REQ));
    any_req                = |req;
  end

endmodule

// File: rtl/kvadd2_adder_arbiter.sv
// rtl/kvadd2_adder_arbiter.sv - packet-granular round-robin arbiter feeding one shared adder stream
module kvadd2_adder_arbiter
  import kvadd2_pkg::*;
#(
  parameter int C_NUM_REQ          = 2,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_AXIS_TID_WIDTH   = 3
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]  req_constant,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]                    s_axis_tready,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0]                    s_axis_tlast,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic                                    m_axis_tlast,
  output logic [C_AXIS_TID_WIDTH-1:0]             m_axis_tid,
  output logic [C_ADDER_BIT_WIDTH-1:0]            ctrl_constant,
  output logic                                    grant_valid,
  output logic [C_AXIS_TID_WIDTH-1:0]             grant_idx
);

  localparam int LP_IDX_W  = idx_width(C_NUM_REQ);
  localparam int LP_DW     = C_AXIS_TDATA_WIDTH;
  localparam int LP_KW     = C_AXIS_TDATA_WIDTH / 8;
  localparam int LP_CW     = C_ADDER_BIT_WIDTH;

  arb_state_e              state_q, state_d;
  logic [LP_IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LP_IDX_W-1:0]     gidx_q, gidx_d;
  logic                    gvalid_q, gvalid_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [LP_DW-1:0]        m_tdata_q, m_tdata_d;
  logic [LP_KW-1:0]        m_tkeep_q, m_tkeep_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [C_AXIS_TID_WIDTH-1:0] m_tid_q, m_tid_d;
  logic [LP_CW-1:0]        const_q, const_d;

  logic [LP_IDX_W-1:0]     arb_idx;
  logic                    arb_any;
  logic                    lock;
  logic                    drain_ok;
  logic                    accept;
  logic                    sel_valid;
  logic                    sel_last;
  logic [LP_DW-1:0]        sel_data;
  logic [LP_KW-1:0]        sel_keep;
  logic [LP_CW-1:0]        sel_const;

  kvadd2_rr_arbiter #(
    .C_NUM_REQ (C_NUM_REQ),
    .IDX_W     (LP_IDX_W)
  ) u_rr (
    .req       (s_axis_tvalid),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    lock          = (state_q == LOCK);
    drain_ok      = ~m_tvalid_q | m_axis_tready;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    sel_const     = '0;
    s_axis_tready = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (gidx_q == LP_IDX_W'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        sel_data         = s_axis_tdata[i*LP_DW +: LP_DW];
        sel_keep         = s_axis_tkeep[i*LP_KW +: LP_KW];
        sel_const        = req_constant[i*LP_CW +: LP_CW];
        s_axis_tready[i] = lock & drain_ok;
      end
    end
    accept = lock & drain_ok & sel_valid;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    gvalid_d = gvalid_q;
    if (state_q == IDLE) begin
      if (arb_any) begin
        gidx_d   = arb_idx;
        gvalid_d = 1'b1;
        state_d  = LOCK;
      end
    end else if (accept && sel_last) begin
      rr_ptr_d = gidx_q;
      gvalid_d = 1'b0;
      state_d  = IDLE;
    end

    // The constant travels with its beat so the adder never sees a stale value across packets.
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    const_d    = const_q;
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = sel_data;
      m_tkeep_d  = sel_keep;
      m_tlast_d  = sel_last;
      m_tid_d    = C_AXIS_TID_WIDTH'(gidx_q);
      const_d    = sel_const;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= LP_IDX_W'(C_NUM_REQ - 1);
      gidx_q     <= '0;
      gvalid_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      const_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      gvalid_q   <= gvalid_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
      const_q    <= const_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tstrb  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign ctrl_constant = const_q;
  assign grant_valid   = gvalid_q;
  assign grant_idx     = C_AXIS_TID_WIDTH'(gidx_q);

endmodule

// File: tb/tb_kvadd2_adder_arbiter.sv
// tb/tb_kvadd2_adder_arbiter.sv - self-checking bench with a packet-level round-robin reference model
module tb_kvadd2_adder_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 32;
  localparam int TW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } sbeat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic          last;
    logic [TW-1:0] tid;
    logic [CW-1:0] cnst;
  } obeat_t;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N*CW-1:0] req_constant;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep, m_axis_tstrb;
  logic [TW-1:0]   m_axis_tid, grant_idx;
  logic [CW-1:0]   ctrl_constant;
  logic            grant_valid;

  kvadd2_adder_arbiter #(
    .C_NUM_REQ(N), .C_AXIS_TDATA_WIDTH(DW), .C_ADDER_BIT_WIDTH(CW), .C_AXIS_TID_WIDTH(TW)
  ) dut (
    .aclk(aclk), .areset(areset), .req_constant(req_constant),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .ctrl_constant(ctrl_constant),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 aclk = ~aclk;

  int            n_checks, n_fail, cyc, mdl_ptr;
  sbeat_t        srcq[N][$];
  int            plen[N][$];
  logic [CW-1:0] cnst[N];
  obeat_t        exp_q[$], got_q[$];
  int            acc_cyc[$], out_cyc[$];
  logic          rdy_pat[$];
  bit            rdy_rand;
  logic          cur_mv, cur_mr, prev_mv, prev_mr, cur_gv;
  obeat_t        cur_ob, prev_ob;
  logic [N-1:0]  cur_str, acc;
  logic [TW-1:0] cur_gidx;

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_constant[i*CW +: CW] = cnst[i];
      if (srcq[i].size() > 0 && srcq[i][0].gap == 0) begin
        s_axis_tvalid[i]         = 1'b1;
        s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
        s_axis_tkeep[i*KW +: KW] = srcq[i][0].keep;
        s_axis_tlast[i]          = srcq[i][0].last;
      end else begin
        s_axis_tvalid[i]         = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
  endtask

  task automatic add_pkt(input int r, input int len, input int gap_beat, input int gap_len);
    sbeat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (k == len - 1);
      b.gap  = (k == gap_beat) ? gap_len : 0;
      srcq[r].push_back(b);
    end
    plen[r].push_back(len);
  endtask

  // Whole packets in round-robin order over requesters that still hold a pending packet.
  task automatic model_build();
    int     off[N];
    int     r, len, cand;
    bit     found;
    sbeat_t sb;
    obeat_t ob;
    for (int i = 0; i < N; i++) off[i] = 0;
    forever begin
      found = 1'b0;
      r     = 0;
      for (int k = 1; k <= N; k++) begin
        cand = (mdl_ptr + k) % N;
        if (!found && plen[cand].size() > 0) begin
          r     = cand;
          found = 1'b1;
        end
      end
      if (!found) break;
      len = plen[r].pop_front();
      for (int b = 0; b < len; b++) begin
        sb      = srcq[r][off[r] + b];
        ob.data = sb.data;
        ob.keep = sb.keep;
        ob.strb = sb.keep;
        ob.last = sb.last;
        ob.tid  = TW'(r);
        ob.cnst = cnst[r];
        exp_q.push_back(ob);
      end
      off[r] += len;
      mdl_ptr = r;
    end
  endtask

  task automatic step();
    sbeat_t sb;
    @(negedge aclk);
    cyc++;
    prev_mv     = cur_mv;
    prev_mr     = cur_mr;
    prev_ob     = cur_ob;
    cur_mv      = m_axis_tvalid;
    cur_mr      = m_axis_tready;
    cur_str     = s_axis_tready;
    cur_gv      = grant_valid;
    cur_gidx    = grant_idx;
    cur_ob.data = m_axis_tdata;
    cur_ob.keep = m_axis_tkeep;
    cur_ob.strb = m_axis_tstrb;
    cur_ob.last = m_axis_tlast;
    cur_ob.tid  = m_axis_tid;
    cur_ob.cnst = ctrl_constant;
    acc = s_axis_tvalid & s_axis_tready;
    for (int i = 0; i < N; i++) if (acc[i]) acc_cyc.push_back(cyc);
    if (cur_mv && cur_mr) begin
      got_q.push_back(cur_ob);
      out_cyc.push_back(cyc);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) srcq[i].delete(0);
      else if (srcq[i].size() > 0 && srcq[i][0].gap > 0) begin
        sb            = srcq[i][0];
        sb.gap        = sb.gap - 1;
        srcq[i][0]    = sb;
      end
    end
    if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
    else if (rdy_rand)      m_axis_tready = 1'($urandom);
    else                    m_axis_tready = 1'b1;
    drive_src();
  endtask

  task automatic run_drain(input string name);
    int k;
    for (k = 0; k < 600; k++) begin
      step();
      if (src_empty() && got_q.size() >= exp_q.size()) break;
    end
    step();
    step();
    if (k == 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout got_beats=%0d required=%0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      plen[i].delete();
    end
    rdy_pat.delete();
    drive_src();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    mdl_ptr = N - 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got=%b required=0", m_axis_tvalid); end
    n_checks++;
    if (s_axis_tready !== '0) begin n_fail++; $display("FAIL reset_s_tready got=%b required=0", s_axis_tready); end
    n_checks++;
    if (grant_valid !== 1'b0 || grant_idx !== '0) begin
      n_fail++; $display("FAIL reset_grant got=%b/%0d required=0/0", grant_valid, grant_idx);
    end
    n_checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tid, ctrl_constant} !== '0) begin
      n_fail++; $display("FAIL reset_payload got=%h/%h/%h/%b/%0d/%h required=all zero",
                         m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tid, ctrl_constant);
    end
    @(posedge aclk);
    #1 areset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (cur_mv !== 1'b0 || cur_gv !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req got=%b/%b required=0/0", cur_mv, cur_gv);
    end
  endtask

  task automatic test_contention();
    int starts[$];
    int want[4];
    want = '{0, 1, 0, 1};
    got_q.delete(); exp_q.delete();
    cnst[0] = 32'd1; cnst[1] = 32'd2; cnst[2] = 32'd3;
    add_pkt(0, 3, -1, 0); add_pkt(0, 3, -1, 0);
    add_pkt(1, 3, -1, 0); add_pkt(1, 3, -1, 0);
    model_build();
    drive_src();
    run_drain("contention");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL contention_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL contention_beat%0d got=%h required=%h", k, got_q[k], exp_q[k]); end
    end
    for (int k = 0; k < got_q.size(); k++) if (k == 0 || got_q[k-1].last) starts.push_back(int'(got_q[k].tid));
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (j >= starts.size() || starts[j] != want[j]) begin
        n_fail++; $display("FAIL contention_order%0d got=%0d required=%0d", j, (j < starts.size()) ? starts[j] : -1, want[j]);
      end
    end
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete(); acc_cyc.delete(); out_cyc.delete();
    cnst[0] = 32'd5;
    add_pkt(0, 4, -1, 0);
    model_build();
    drive_src();
    run_drain("single");
    n_checks++;
    if (got_q.size() != 4) begin n_fail++; $display("FAIL single_count got=%0d required=4", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_beat%0d got=%h required=%h", k, got_q[k], exp_q[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= acc_cyc.size() || k >= out_cyc.size() || out_cyc[k] != acc_cyc[k] + 1) begin
        n_fail++; $display("FAIL single_latency%0d accepts=%0d outputs=%0d required_delay=1", k, acc_cyc.size(), out_cyc.size());
      end
    end
    n_checks++;
    if (got_q.size() < 4 || got_q[3].last !== 1'b1 || got_q[3].cnst !== 32'd5 || got_q[3].tid !== '0) begin
      n_fail++; $display("FAIL single_last_beat got_beats=%0d required tlast=1 tid=0 const=5", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    int k;
    got_q.delete(); exp_q.delete();
    cnst[2] = $urandom;
    add_pkt(2, 4, -1, 0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    model_build();
    drive_src();
    for (k = 0; k < 200; k++) begin
      step();
      if (prev_mv && !prev_mr) begin
        n_checks++;
        if (cur_mv !== 1'b1 || cur_ob !== prev_ob) begin
          n_fail++; $display("FAIL bp_hold got=%b/%h required=1/%h", cur_mv, cur_ob, prev_ob);
        end
      end
      if (cur_mv && !cur_mr) begin
        n_checks++;
        if (cur_str !== '0) begin n_fail++; $display("FAIL bp_s_tready got=%b required=0", cur_str); end
      end
      if (src_empty() && got_q.size() >= exp_q.size() && rdy_pat.size() == 0) break;
    end
    step();
    step();
    n_checks++;
    if (k == 200 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL bp_beat%0d got=%h required=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_gap();
    int  k;
    bit  started;
    got_q.delete(); exp_q.delete();
    cnst[0] = $urandom; cnst[1] = $urandom;
    add_pkt(0, 1, -1, 0);
    model_build();
    drive_src();
    run_drain("gap_pre");
    got_q.delete(); exp_q.delete();
    add_pkt(1, 6, 3, 3);
    add_pkt(0, 2, -1, 0);
    model_build();
    drive_src();
    started = 1'b0;
    for (k = 0; k < 200; k++) begin
      step();
      if (cur_gv) started = 1'b1;
      if (started && srcq[1].size() > 0) begin
        n_checks++;
        if (cur_gidx !== TW'(1) || cur_str[0] !== 1'b0) begin
          n_fail++; $display("FAIL gap_lock got grant_idx=%0d s_tready0=%b required=1/0", cur_gidx, cur_str[0]);
        end
      end
      if (src_empty() && got_q.size() >= exp_q.size()) break;
    end
    step();
    step();
    n_checks++;
    if (k == 200 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gap_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL gap_beat%0d got=%h required=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    got_q.delete(); exp_q.delete();
    cnst[0] = $urandom; cnst[1] = $urandom;
    add_pkt(0, 1, -1, 0);
    model_build();
    drive_src();
    run_drain("rst_pre");
    acc_cyc.delete();
    add_pkt(0, 5, -1, 0);
    drive_src();
    for (k = 0; k < 50 && acc_cyc.size() < 2; k++) step();
    n_checks++;
    if (acc_cyc.size() != 2) begin n_fail++; $display("FAIL rst_mid_setup accepts=%0d required=2", acc_cyc.size()); end
    areset = 1'b1;
    #1;
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, grant_valid, grant_idx} !== '0) begin
      n_fail++; $display("FAIL rst_mid_ctrl got=%b/%b/%b/%0d required=all zero", m_axis_tvalid, s_axis_tready, grant_valid, grant_idx);
    end
    n_checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tid, ctrl_constant} !== '0) begin
      n_fail++; $display("FAIL rst_mid_payload got=%h/%h/%b/%0d/%h required=all zero",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, ctrl_constant);
    end
    do_reset();
    got_q.delete(); exp_q.delete();
    add_pkt(1, 2, -1, 0);
    add_pkt(0, 2, -1, 0);
    model_build();
    drive_src();
    run_drain("rst_post");
    n_checks++;
    if (got_q.size() == 0 || got_q[0].tid !== TW'(0)) begin
      n_fail++; $display("FAIL rst_first_grant got=%0d required=0", (got_q.size() > 0) ? int'(got_q[0].tid) : -1);
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL rst_post_beat%0d got=%h required=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_three_way();
    int starts[$];
    int want[4];
    want = '{0, 1, 2, 0};
    do_reset();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) cnst[i] = $urandom;
    add_pkt(0, 2, -1, 0); add_pkt(0, 1, -1, 0);
    add_pkt(1, 2, -1, 0);
    add_pkt(2, 3, -1, 0);
    model_build();
    drive_src();
    run_drain("three_way");
    for (int k = 0; k < got_q.size(); k++) if (k == 0 || got_q[k-1].last) starts.push_back(int'(got_q[k].tid));
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (j >= starts.size() || starts[j] != want[j]) begin
        n_fail++; $display("FAIL three_way_order%0d got=%0d required=%0d", j, (j < starts.size()) ? starts[j] : -1, want[j]);
      end
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL three_way_beat%0d got=%h required=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_random_mix();
    int len;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) cnst[i] = $urandom;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 3; p++) begin
        len = 1 + int'($urandom % 4);
        if (len > 1) add_pkt(i, len, 1 + int'($urandom % (len - 1)), int'($urandom % 3));
        else         add_pkt(i, len, -1, 0);
      end
    end
    rdy_rand = 1'b1;
    model_build();
    drive_src();
    run_drain("random");
    rdy_rand = 1'b0;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL random_beat%0d got=%h required=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    mdl_ptr       = N - 1;
    rdy_rand      = 1'b0;
    cur_mv        = 1'b0;
    cur_mr        = 1'b1;
    cur_ob        = '0;
    areset        = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) cnst[i] = '0;
    req_constant  = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_three_way();
    test_random_mix();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
